// File: rtl/ncpu32k_mem_pkg.sv
// Shared constants for the ncpu32k memory arrays.
//   - byte_lanes(): number of 8-bit lanes in a DW-bit word
//   - CollisionWinner: port whose bytes win when both ports write the same
//     byte of the same address on the same edge
package ncpu32k_mem_pkg;

    typedef enum logic {PortA, PortB} port_e;

    localparam int unsigned DefaultDw    = 32;
    localparam port_e       CollisionWinner = PortB;

    function automatic int unsigned byte_lanes(input int unsigned dw);
        return dw / 8;
    endfunction

    localparam int unsigned DefaultLanes = byte_lanes(DefaultDw);

endpackage

// File: rtl/ncpu32k_tdpram_bytewe_if.sv
// Bus bundle for the true dual-port byte-write RAM.
//   master: drives en/we/addr/din of both ports, receives dout
//   slave : the RAM side
interface ncpu32k_tdpram_bytewe_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
);
    logic              en_a;
    logic [DW/8-1:0]   we_a;
    logic [AW-1:0]     addr_a;
    logic [DW-1:0]     din_a;
    logic [DW-1:0]     dout_a;

    logic              en_b;
    logic [DW/8-1:0]   we_b;
    logic [AW-1:0]     addr_b;
    logic [DW-1:0]     din_b;
    logic [DW-1:0]     dout_b;

    modport master (
        output en_a, we_a, addr_a, din_a,
        output en_b, we_b, addr_b, din_b,
        input  dout_a, dout_b
    );

    modport slave (
        input  en_a, we_a, addr_a, din_a,
        input  en_b, we_b, addr_b, din_b,
        output dout_a, dout_b
    );
endinterface

// File: rtl/tdpram_byte_lane.sv
// One 8-bit lane of the dual-port RAM: storage plus both write ports.
// Read data is the pre-edge (old) contents at each port's address; the
// caller registers it and applies any write-first bypass.
//   clk_i            clock
//   wr_a_i/wr_b_i    qualified per-port write strobes (never both for the
//                    same address; the caller resolves collisions)
//   addr_*_i, din_*_i  port address / write byte
//   rd_*_o           current contents at addr_*_i
module tdpram_byte_lane #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          wr_a_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic [7:0]    din_a_i,
    output logic [7:0]    rd_a_o,
    input  logic          wr_b_i,
    input  logic [AW-1:0] addr_b_i,
    input  logic [7:0]    din_b_i,
    output logic [7:0]    rd_b_o
);
    logic [7:0] mem [2**AW];

    always_ff @(posedge clk_i) begin
        if (wr_a_i) mem[addr_a_i] <= din_a_i;
        if (wr_b_i) mem[addr_b_i] <= din_b_i;
    end

    assign rd_a_o = mem[addr_a_i];
    assign rd_b_o = mem[addr_b_i];
endmodule

// File: rtl/ncpu32k_tdpram_bytewe.sv
// True dual-port synchronous RAM with per-byte write enables (L2 data array).
// Build option: define NCPU_TDPRAM_WRITE_FIRST_EN for write-first same-port
// read-during-write; default is read-first. Cross-port reads always see the
// old word, and on a same-byte write collision port B wins.
//   clk  shared clock
//   rst  synchronous active-high reset: clears dout, blocks writes
//   bus  slave side of ncpu32k_tdpram_bytewe_if (en/we/addr/din/dout per port)
module ncpu32k_tdpram_bytewe
    import ncpu32k_mem_pkg::*;
#(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    ncpu32k_tdpram_bytewe_if.slave   bus
);
    localparam int unsigned NumLanes = byte_lanes(DW);

    logic [NumLanes-1:0] wr_a, wr_b;
    logic [DW-1:0]       old_a, old_b;
    logic [DW-1:0]       rd_a, rd_b;
    logic [DW-1:0]       dout_a_d, dout_a_q, dout_b_d, dout_b_q;
    logic                same_addr;

    assign same_addr = bus.en_a && bus.en_b && (bus.addr_a == bus.addr_b);

    // Qualify strobes; the losing port drops bytes the winner also writes.
    always_comb begin
        wr_a = '0;
        wr_b = '0;
        if (!rst) begin
            if (bus.en_a) wr_a = bus.we_a;
            if (bus.en_b) wr_b = bus.we_b;
        end
        if (same_addr) begin
            if (CollisionWinner == PortB) wr_a = wr_a & ~wr_b;
            else                          wr_b = wr_b & ~wr_a;
        end
    end

    for (genvar i = 0; i < NumLanes; i++) begin : g_lane
        tdpram_byte_lane #(
            .AW (AW)
        ) u_lane (
            .clk_i    (clk),
            .wr_a_i   (wr_a[i]),
            .addr_a_i (bus.addr_a),
            .din_a_i  (bus.din_a[8*i +: 8]),
            .rd_a_o   (old_a[8*i +: 8]),
            .wr_b_i   (wr_b[i]),
            .addr_b_i (bus.addr_b),
            .din_b_i  (bus.din_b[8*i +: 8]),
            .rd_b_o   (old_b[8*i +: 8])
        );
    end

    // Same-port bypass uses the port's own byte enables, not the
    // collision-resolved ones.
    always_comb begin
        rd_a = old_a;
        rd_b = old_b;
`ifdef NCPU_TDPRAM_WRITE_FIRST_EN
        for (int i = 0; i < int'(NumLanes); i++) begin
            if (bus.we_a[i]) rd_a[8*i +: 8] = bus.din_a[8*i +: 8];
            if (bus.we_b[i]) rd_b[8*i +: 8] = bus.din_b[8*i +: 8];
        end
`endif
    end

    always_comb begin
        dout_a_d = dout_a_q;
        dout_b_d = dout_b_q;
        if (bus.en_a) dout_a_d = rd_a;
        if (bus.en_b) dout_b_d = rd_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
        end else begin
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
        end
    end

    assign bus.dout_a = dout_a_q;
    assign bus.dout_b = dout_b_q;
endmodule

// File: tb/tb_ncpu32k_tdpram_bytewe.sv
// Directed self-checking bench for ncpu32k_tdpram_bytewe (AW=10, DW=32).
module tb_ncpu32k_tdpram_bytewe;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_rdw;

    always #5 clk = ~clk;

    ncpu32k_tdpram_bytewe_if #(.AW(10), .DW(32)) bus ();

    ncpu32k_tdpram_bytewe #(
        .AW (10),
        .DW (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic en, input logic [3:0] we, input logic [9:0] addr,
                         input logic [31:0] din);
        bus.en_a = en; bus.we_a = we; bus.addr_a = addr; bus.din_a = din;
    endtask

    task automatic set_b(input logic en, input logic [3:0] we, input logic [9:0] addr,
                         input logic [31:0] din);
        bus.en_b = en; bus.we_b = we; bus.addr_b = addr; bus.din_b = din;
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_a(1'b0, 4'h0, 10'h000, 32'h0);
        set_b(1'b0, 4'h0, 10'h000, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // Writes during reset must be discarded.
        set_a(1'b1, 4'hF, 10'h040, 32'h12345678);
        tick();
        tick();
        check("rst_dout_a", bus.dout_a, 32'h0);
        check("rst_dout_b", bus.dout_b, 32'h0);
        rst = 1'b0;

        // Full write on A, read on B.
        set_a(1'b1, 4'hF, 10'h005, 32'hDEADBEEF);
        tick();
        set_a(1'b0, 4'h0, 10'h000, 32'h0);
        set_b(1'b1, 4'h0, 10'h005, 32'h0);
        tick();
        check("a_wr_b_rd", bus.dout_b, 32'hDEADBEEF);

        // Byte masks on B.
        set_b(1'b0, 4'h0, 10'h000, 32'h0);
        set_a(1'b1, 4'hF, 10'h010, 32'h11223344);
        tick();
        set_a(1'b0, 4'h0, 10'h000, 32'h0);
        set_b(1'b1, 4'b0011, 10'h010, 32'hAABBCCDD);
`ifdef NCPU_TDPRAM_WRITE_FIRST_EN
        exp_rdw = 32'h1122CCDD;
`else
        exp_rdw = 32'h11223344;
`endif
        tick();
        check("b_rdw_mask", bus.dout_b, exp_rdw);
        set_b(1'b1, 4'h0, 10'h010, 32'h0);
        tick();
        check("mask_lo", bus.dout_b, 32'h1122CCDD);
        set_b(1'b1, 4'b1100, 10'h010, 32'h55660000);
        tick();
        set_b(1'b1, 4'h0, 10'h010, 32'h0);
        tick();
        check("mask_hi", bus.dout_b, 32'h5566CCDD);
        set_b(1'b0, 4'h0, 10'h000, 32'h0);

        // Same-port read-during-write on A.
        set_a(1'b1, 4'hF, 10'h020, 32'h0);
        tick();
        set_a(1'b1, 4'hF, 10'h020, 32'hCAFEF00D);
`ifdef NCPU_TDPRAM_WRITE_FIRST_EN
        exp_rdw = 32'hCAFEF00D;
`else
        exp_rdw = 32'h00000000;
`endif
        tick();
        check("a_rdw", bus.dout_a, exp_rdw);
        set_a(1'b1, 4'h0, 10'h020, 32'h0);
        tick();
        check("a_rdw_after", bus.dout_a, 32'hCAFEF00D);

        // Cross-port partial collision: B wins only its enabled bytes.
        set_a(1'b1, 4'hF, 10'h030, 32'h11111111);
        set_b(1'b1, 4'b0011, 10'h030, 32'h22222222);
        tick();
        set_a(1'b1, 4'h0, 10'h030, 32'h0);
        set_b(1'b1, 4'h0, 10'h030, 32'h0);
        tick();
        check("coll_part_a", bus.dout_a, 32'h11112222);
        check("coll_part_b", bus.dout_b, 32'h11112222);

        // Full collision: B wins everything.
        set_a(1'b1, 4'hF, 10'h031, 32'hAAAAAAAA);
        set_b(1'b1, 4'hF, 10'h031, 32'hBBBBBBBB);
        tick();
        set_a(1'b1, 4'h0, 10'h031, 32'h0);
        set_b(1'b0, 4'h0, 10'h000, 32'h0);
        tick();
        check("coll_full", bus.dout_a, 32'hBBBBBBBB);

        // Cross-port read-during-write sees the old word.
        set_a(1'b1, 4'hF, 10'h005, 32'h01020304);
        set_b(1'b1, 4'h0, 10'h005, 32'h0);
        tick();
        check("xport_old", bus.dout_b, 32'hDEADBEEF);
        set_a(1'b0, 4'h0, 10'h000, 32'h0);
        tick();
        check("xport_new", bus.dout_b, 32'h01020304);
        set_b(1'b0, 4'h0, 10'h000, 32'h0);

        // Hold: en_a=0 with toggling inputs.
        set_a(1'b1, 4'h0, 10'h010, 32'h0);
        tick();
        check("hold_pre", bus.dout_a, 32'h5566CCDD);
        for (int i = 0; i < 5; i++) begin
            set_a(1'b0, 4'(i + 1) | 4'h8, (i % 2 == 0) ? 10'h010 : 10'h005, $urandom);
            tick();
            check($sformatf("hold_%0d", i), bus.dout_a, 32'h5566CCDD);
        end
        set_a(1'b1, 4'h0, 10'h005, 32'h0);
        tick();
        check("hold_mem_005", bus.dout_a, 32'h01020304);
        set_a(1'b1, 4'h0, 10'h010, 32'h0);
        tick();
        check("hold_mem_010", bus.dout_a, 32'h5566CCDD);

        // Reset mid-burst: in-flight write dropped, contents retained.
        set_a(1'b1, 4'hF, 10'h040, 32'h0BADF00D);
        tick();
        rst = 1'b1;
        set_a(1'b1, 4'hF, 10'h040, 32'h12345678);
        set_b(1'b1, 4'hF, 10'h041, 32'h87654321);
        tick();
        tick();
        check("rst2_dout_a", bus.dout_a, 32'h0);
        check("rst2_dout_b", bus.dout_b, 32'h0);
        rst = 1'b0;
        set_a(1'b1, 4'h0, 10'h040, 32'h0);
        set_b(1'b1, 4'h0, 10'h005, 32'h0);
        tick();
        check("rst_retain", bus.dout_a, 32'h0BADF00D);
        check("rst_retain_b", bus.dout_b, 32'h01020304);
        idle();
        tick();
        check("idle_hold", bus.dout_a, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
